sd_dat_block_tx: RTL

Single-lane SD data-block transmitter for the SD card write path. It takes bytes over a valid/ready handshake and frames them on DAT0 as start bit, data MSB-first, CRC-16, then end bit. It instantiates the serial CRC-16 LFSR (x^16+x^12+x^5+1, zero init) and streams each data bit through it. It sits between the write-data buffer upstream and the DAT pad driver downstream.

---
 rtl/sd_pkg.sv | 7 +
 rtl/serial_CRC16.sv | 13 +
 rtl/sd_dat_block_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: shared state encoding and framing constants for the SD DAT transmit path
package sd_pkg;
    typedef enum logic [2:0] {IDLE, START_BIT, DATA, CRC, END_BIT, FINISH} state_t;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic SD_START_BIT = 1'b0;
    localparam logic SD_END_BIT = 1'b1;
endpackage

// File: rtl/serial_CRC16.sv
// serial_CRC16: bit-serial CRC-16 LFSR (x^16+x^12+x^5+1), zero initial value
module serial_CRC16 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENA,
    input  logic        BITVAL,
    output logic [15:0] CRC
);
    always_ff @(posedge CLK) begin
        if (RST) CRC <= '0;
        else if (ENA) CRC <= {CRC[14:0], 1'b0} ^ ({16{CRC[15] ^ BITVAL}} & sd_pkg::CRC16_POLY);
    end
endmodule

// File: rtl/sd_dat_block_tx.sv
// sd_dat_block_tx: frames one data block on DAT0 as start bit, data MSB-first, CRC-16, end bit
module sd_dat_block_tx
    import sd_pkg::*;
#(
    parameter int BLOCK_BYTES = 512,
    parameter int CNT_W = 12
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BIT_EN,
    input  logic       START,
    input  logic [7:0] DIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    output logic       DAT_OUT,
    output logic       DAT_OE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);
    localparam logic [CNT_W:0] LAST = (CNT_W + 1)'(BLOCK_BYTES);
    state_t state;
    logic [7:0] hold, sr, next_byte;
    logic [15:0] crc_sr, crc;
    logic [CNT_W:0] acc_cnt, byte_cnt;
    logic [2:0] bit_cnt;
    logic [4:0] crc_cnt;
    logic hold_full, accept, avail, need, take, underrun, crc_clr, crc_ena;

    assign DIN_READY = BUSY && !hold_full && acc_cnt < LAST;
    assign accept = DIN_VALID && DIN_READY;
    // a byte accepted on the load edge bypasses the hold register straight into sr
    assign avail = hold_full || accept;
    assign next_byte = hold_full ? hold : DIN;
    assign need = BIT_EN && (state == START_BIT || (state == DATA && bit_cnt == 3'd7 && byte_cnt != LAST));
    assign take = need && avail;
    assign underrun = need && !avail;
    assign crc_clr = state == IDLE && START;
    assign crc_ena = state == DATA && BIT_EN;

    serial_CRC16 u_crc (
        .CLK(CLK),
        .RST(RST | crc_clr),
        .ENA(crc_ena),
        .BITVAL(sr[7]),
        .CRC(crc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            DAT_OUT <= 1'b1;
            DAT_OE <= 1'b0;
            BUSY <= 1'b0;
            DONE <= 1'b0;
            ERR <= 1'b0;
            hold <= '0;
            hold_full <= 1'b0;
            sr <= '0;
            crc_sr <= '0;
            acc_cnt <= '0;
            byte_cnt <= '0;
            bit_cnt <= '0;
            crc_cnt <= '0;
        end else begin
            DONE <= 1'b0;
            ERR <= 1'b0;
            if (accept) acc_cnt <= acc_cnt + 1'b1;
            if (accept && !take) hold <= DIN;
            hold_full <= take ? 1'b0 : (accept || hold_full);
            if (take) begin
                sr <= next_byte;
                byte_cnt <= byte_cnt + 1'b1;
            end
            case (state)
                IDLE: if (START) begin
                    state <= START_BIT;
                    BUSY <= 1'b1;
                    acc_cnt <= '0;
                    byte_cnt <= '0;
                    bit_cnt <= '0;
                    crc_cnt <= '0;
                end
                START_BIT: if (take) begin
                    DAT_OE <= 1'b1;
                    DAT_OUT <= SD_START_BIT;
                    state <= DATA;
                end
                DATA: if (BIT_EN) begin
                    DAT_OUT <= sr[7];
                    if (!take) sr <= {sr[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7 && byte_cnt == LAST) state <= CRC;
                end
                CRC: if (BIT_EN) begin
                    DAT_OUT <= crc_cnt == 5'd0 ? crc[15] : crc_sr[15];
                    crc_sr <= crc_cnt == 5'd0 ? {crc[14:0], 1'b0} : {crc_sr[14:0], 1'b0};
                    crc_cnt <= crc_cnt + 1'b1;
                    if (crc_cnt == 5'd15) state <= END_BIT;
                end
                END_BIT: if (BIT_EN) begin
                    DAT_OUT <= SD_END_BIT;
                    state <= FINISH;
                end
                FINISH: begin
                    DAT_OE <= 1'b0;
                    DONE <= 1'b1;
                    BUSY <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (underrun) begin
                DAT_OUT <= 1'b1;
                DAT_OE <= 1'b0;
                DONE <= 1'b1;
                ERR <= 1'b1;
                BUSY <= 1'b0;
                hold_full <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule
